// File: rtl/wm_cycle_sched_if.sv
// Command, duration, subtractor and status signals of the washing-machine phase scheduler.
// The master side is the program controller and the subtractor; the slave side is the scheduler.
interface wm_cycle_sched_if;
  logic        tick_1hz;
  logic        start;
  logic        pause;
  logic        abort;
  logic [11:0] wash_t;
  logic [11:0] rinse_t;
  logic [11:0] spin_t;
  logic [11:0] sub_a;
  logic [11:0] sub_b;
  logic [11:0] sub_diff;
  logic [1:0]  phase;
  logic [11:0] remain;
  logic        running;
  logic        paused;
  logic        done;
  logic        err;

  modport master (
    output tick_1hz, start, pause, abort, wash_t, rinse_t, spin_t, sub_diff,
    input  sub_a, sub_b, phase, remain, running, paused, done, err
  );

  modport slave (
    input  tick_1hz, start, pause, abort, wash_t, rinse_t, spin_t, sub_diff,
    output sub_a, sub_b, phase, remain, running, paused, done, err
  );
endinterface

// File: rtl/wm_cycle_sched.sv
// Wash/rinse/spin phase sequencer with a 3-digit BCD countdown.
// The countdown decrements through an external combinational BCD subtractor.
module wm_cycle_sched #(
  parameter logic [11:0] MAX_BCD = 12'h255
) (
  input  logic             clk,
  input  logic             rst_n,
  wm_cycle_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ADV} state_t;

  state_t      state, state_nxt;
  logic [1:0]  phase, phase_nxt;
  logic [11:0] remain, remain_nxt;
  logic        done, done_nxt;
  logic        err, err_nxt;
  logic        load_shadow;
  logic [11:0] sh_wash, sh_rinse, sh_spin;
  logic [11:0] cap_wash, cap_rinse, cap_spin;
  logic        cap_ok;
  logic [1:0]  entry_phase, adv_phase;

  function automatic logic digits_ok(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // With all digits legal, packed BCD orders the same as its numeric value.
  function automatic logic [11:0] sat_bcd(input logic [11:0] v);
    return (v > MAX_BCD) ? MAX_BCD : v;
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] cur,
                                            input logic [11:0] w,
                                            input logic [11:0] r,
                                            input logic [11:0] s);
    if (cur == 2'd0 && w != 12'h000) return 2'd1;
    if (cur <= 2'd1 && r != 12'h000) return 2'd2;
    if (cur <= 2'd2 && s != 12'h000) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [11:0] phase_dur(input logic [1:0] p,
                                            input logic [11:0] w,
                                            input logic [11:0] r,
                                            input logic [11:0] s);
    case (p)
      2'd1:    return w;
      2'd2:    return r;
      2'd3:    return s;
      default: return 12'h000;
    endcase
  endfunction

  assign cap_ok      = digits_ok(bus.wash_t) && digits_ok(bus.rinse_t) && digits_ok(bus.spin_t);
  assign cap_wash    = sat_bcd(bus.wash_t);
  assign cap_rinse   = sat_bcd(bus.rinse_t);
  assign cap_spin    = sat_bcd(bus.spin_t);
  assign entry_phase = next_phase(2'd0, cap_wash, cap_rinse, cap_spin);
  assign adv_phase   = next_phase(phase, sh_wash, sh_rinse, sh_spin);

  assign bus.sub_a   = remain;
  assign bus.sub_b   = 12'h001;
  assign bus.phase   = phase;
  assign bus.remain  = remain;
  assign bus.running = (state == RUN);
  assign bus.paused  = (state == PAUSE);
  assign bus.done    = done;
  assign bus.err     = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    remain_nxt  = remain;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    load_shadow = 1'b0;
    if (bus.abort) begin
      state_nxt  = IDLE;
      phase_nxt  = 2'd0;
      remain_nxt = 12'h000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (!cap_ok) begin
              err_nxt = 1'b1;
            end else begin
              load_shadow = 1'b1;
              if (entry_phase == 2'd0) begin
                done_nxt = 1'b1;
              end else begin
                state_nxt  = RUN;
                phase_nxt  = entry_phase;
                remain_nxt = phase_dur(entry_phase, cap_wash, cap_rinse, cap_spin);
              end
            end
          end
        end
        RUN: begin
          // Borrow from the subtractor is never latched: 000 hands over instead.
          if (bus.pause)                 state_nxt  = PAUSE;
          else if (remain == 12'h000)    state_nxt  = ADV;
          else if (bus.tick_1hz)         remain_nxt = bus.sub_diff;
        end
        PAUSE: begin
          if (bus.pause) state_nxt = RUN;
        end
        ADV: begin
          if (adv_phase == 2'd0) begin
            state_nxt  = IDLE;
            phase_nxt  = 2'd0;
            remain_nxt = 12'h000;
            done_nxt   = 1'b1;
          end else begin
            state_nxt  = RUN;
            phase_nxt  = adv_phase;
            remain_nxt = phase_dur(adv_phase, sh_wash, sh_rinse, sh_spin);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 2'd0;
      remain   <= 12'h000;
      done     <= 1'b0;
      err      <= 1'b0;
      sh_wash  <= 12'h000;
      sh_rinse <= 12'h000;
      sh_spin  <= 12'h000;
    end else begin
      phase  <= phase_nxt;
      remain <= remain_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      if (load_shadow) begin
        sh_wash  <= cap_wash;
        sh_rinse <= cap_rinse;
        sh_spin  <= cap_spin;
      end
    end
  end

endmodule

// File: tb/tb_wm_cycle_sched.sv
// Bench for wm_cycle_sched: directed scenarios plus random traffic against a
// queue-based model that counts seconds as plain integers.
module tb_wm_cycle_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  wm_cycle_sched_if bus ();

  wm_cycle_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [11:0] v);
    for (int k = 0; k < 3; k++)
      if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Shared BCD subtractor seen by the scheduler; wraps 000 to 999 like real hardware.
  assign bus.sub_diff = (bus.sub_a == 12'h000) ? 12'h999 : int2bcd(bcd2int(bus.sub_a) - 1);

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ADV = 3;
  int m_mode, m_phase, m_secs;
  bit m_done, m_err;
  int q_ph[$];
  int q_sec[$];

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_secs = 0; m_done = 0; m_err = 0;
    q_ph.delete(); q_sec.delete();
  endtask

  task automatic model_step(input bit st, input bit pa, input bit ab, input bit tk,
                            input logic [11:0] w, input logic [11:0] r, input logic [11:0] s);
    int d;
    logic [11:0] durs [3];
    m_done = 0;
    m_err  = 0;
    durs[0] = w; durs[1] = r; durs[2] = s;
    if (ab) begin
      m_mode = M_IDLE; m_phase = 0; m_secs = 0;
      q_ph.delete(); q_sec.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (st) begin
          if (!bcd_ok(w) || !bcd_ok(r) || !bcd_ok(s)) begin
            m_err = 1;
          end else begin
            q_ph.delete(); q_sec.delete();
            for (int i = 0; i < 3; i++) begin
              d = bcd2int(durs[i]);
              if (d > 255) d = 255;
              if (d > 0) begin q_ph.push_back(i + 1); q_sec.push_back(d); end
            end
            if (q_ph.size() == 0) m_done = 1;
            else begin
              m_phase = q_ph.pop_front(); m_secs = q_sec.pop_front(); m_mode = M_RUN;
            end
          end
        end
        M_RUN: begin
          if (pa)               m_mode = M_PAUSE;
          else if (m_secs == 0) m_mode = M_ADV;
          else if (tk)          m_secs--;
        end
        M_PAUSE: if (pa) m_mode = M_RUN;
        default: begin
          if (q_ph.size() == 0) begin
            m_phase = 0; m_secs = 0; m_done = 1; m_mode = M_IDLE;
          end else begin
            m_phase = q_ph.pop_front(); m_secs = q_sec.pop_front(); m_mode = M_RUN;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("phase",   12'(bus.phase),   12'(m_phase));
    check("remain",  bus.remain,       int2bcd(m_secs));
    check("sub_a",   bus.sub_a,        int2bcd(m_secs));
    check("sub_b",   bus.sub_b,        12'h001);
    check("running", 12'(bus.running), 12'(m_mode == M_RUN));
    check("paused",  12'(bus.paused),  12'(m_mode == M_PAUSE));
    check("done",    12'(bus.done),    12'(m_done));
    check("err",     12'(bus.err),     12'(m_err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_phase"},   12'(bus.phase),   12'h000);
    check({tag, "_remain"},  bus.remain,       12'h000);
    check({tag, "_sub_a"},   bus.sub_a,        12'h000);
    check({tag, "_running"}, 12'(bus.running), 12'h000);
    check({tag, "_paused"},  12'(bus.paused),  12'h000);
    check({tag, "_done"},    12'(bus.done),    12'h000);
    check({tag, "_err"},     12'(bus.err),     12'h000);
  endtask

  task automatic do_cycle();
    @(posedge clk);
    model_step(bus.start, bus.pause, bus.abort, bus.tick_1hz, bus.wash_t, bus.rinse_t, bus.spin_t);
    #1;
    check_all();
    bus.start = 0; bus.pause = 0; bus.abort = 0; bus.tick_1hz = 0;
  endtask

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      bus.tick_1hz = (period > 0) && (i % period == period - 1);
      do_cycle();
    end
  endtask

  task automatic go(input logic [11:0] w, input logic [11:0] r, input logic [11:0] s);
    bus.wash_t = w; bus.rinse_t = r; bus.spin_t = s;
    bus.start = 1;
    do_cycle();
  endtask

  task automatic do_abort();
    bus.abort = 1;
    do_cycle();
  endtask

  function automatic logic [11:0] rnd_dur();
    logic [3:0] h, t, u;
    if ($urandom % 4 == 0) return 12'h000;
    h = ($urandom % 16 == 0) ? 4'd3 : 4'd0;
    t = 4'($urandom_range(0, 1));
    u = 4'($urandom_range(0, 9));
    if ($urandom % 12 == 0) u = 4'($urandom_range(10, 15));
    return {h, t, u};
  endfunction

  initial begin
    rst_n = 0;
    bus.start = 0; bus.pause = 0; bus.abort = 0; bus.tick_1hz = 0;
    bus.wash_t = 12'h000; bus.rinse_t = 12'h000; bus.spin_t = 12'h000;
    model_reset();
    #3;
    check_zero("reset");
    check("reset_sub_b", bus.sub_b, 12'h001);
    @(negedge clk);
    rst_n = 1;

    // Full program with ticks every 10 cycles.
    go(12'h003, 12'h002, 12'h001);
    check("start_phase", 12'(bus.phase), 12'h001);
    check("start_remain", bus.remain, 12'h003);
    run(100, 10);
    check("prog_end_phase", 12'(bus.phase), 12'h000);

    // BCD borrow, then clamp.
    go(12'h100, 12'h000, 12'h000);
    run(1, 1);
    check("borrow", bus.remain, 12'h099);
    do_abort();
    go(12'h300, 12'h000, 12'h000);
    check("clamp", bus.remain, 12'h255);
    do_abort();

    // Zero-phase skip and all-zero program.
    go(12'h000, 12'h005, 12'h000);
    check("skip_phase", 12'(bus.phase), 12'h002);
    run(30, 3);
    go(12'h000, 12'h000, 12'h000);
    check("allzero_done", 12'(bus.done), 12'h001);
    check("allzero_phase", 12'(bus.phase), 12'h000);
    run(2, 0);

    // Pause holds the countdown.
    go(12'h010, 12'h000, 12'h000);
    run(3, 1);
    bus.pause = 1;
    do_cycle();
    run(5, 1);
    check("pause_hold", bus.remain, 12'h007);
    check("pause_flag", 12'(bus.paused), 12'h001);
    bus.pause = 1;
    do_cycle();
    run(1, 1);
    check("pause_resume", bus.remain, 12'h006);
    do_abort();

    // Abort at 004 in rinse.
    go(12'h001, 12'h006, 12'h000);
    run(1, 1);
    run(2, 0);
    run(2, 1);
    check("pre_abort_phase", 12'(bus.phase), 12'h002);
    check("pre_abort_remain", bus.remain, 12'h004);
    do_abort();
    check_zero("abort");
    run(3, 0);

    // Asynchronous reset at the same point, between clock edges.
    go(12'h001, 12'h006, 12'h000);
    run(1, 1);
    run(2, 0);
    run(2, 1);
    check("pre_rst_remain", bus.remain, 12'h004);
    #2;
    rst_n = 0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    run(3, 1);

    // Illegal digit rejected.
    go(12'h0A5, 12'h000, 12'h000);
    check("err_pulse", 12'(bus.err), 12'h001);
    check("err_idle", 12'(bus.running), 12'h000);
    run(2, 0);

    // Start, pause and tick together from IDLE.
    bus.wash_t = 12'h007; bus.rinse_t = 12'h000; bus.spin_t = 12'h000;
    bus.start = 1; bus.pause = 1; bus.tick_1hz = 1;
    do_cycle();
    check("collide_remain", bus.remain, 12'h007);
    check("collide_paused", 12'(bus.paused), 12'h000);
    do_abort();

    // Tick arriving while remain is 000 is dropped.
    go(12'h001, 12'h002, 12'h000);
    run(1, 1);
    bus.tick_1hz = 1;
    do_cycle();
    check("handover_zero", bus.remain, 12'h000);
    bus.tick_1hz = 1;
    do_cycle();
    check("handover_phase", 12'(bus.phase), 12'h002);
    check("handover_remain", bus.remain, 12'h002);
    run(10, 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bus.start = ($urandom % 16 == 0);
      if (bus.start) begin
        bus.wash_t = rnd_dur(); bus.rinse_t = rnd_dur(); bus.spin_t = rnd_dur();
      end
      bus.pause    = ($urandom % 24 == 0);
      bus.abort    = ($urandom % 97 == 0);
      bus.tick_1hz = ($urandom % 2 == 0);
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wm_cycle_sched.md
# wm_cycle_sched

Phase scheduler for the washing-machine countdown. It sequences the three wash-program phases (wash, rinse, spin) and keeps the remaining time of the active phase in 3-digit BCD. It decrements that time once per second through the shared combinational BCD subtractor, and drives the phase and remaining-time outputs consumed by the display and motor control blocks.

## Interface
Parameters:
- `MAX_BCD`, 12'h255, largest legal phase duration; larger captured values are clamped to it.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_1hz` in 1: one-cycle pulse per second.
- `start` in 1: one-cycle pulse; starts a program from IDLE.
- `pause` in 1: one-cycle pulse; toggles RUN/PAUSE.
- `abort` in 1: one-cycle pulse; returns to IDLE from any state.
- `wash_t`, `rinse_t`, `spin_t` in 12: phase durations, BCD `{hundreds,tens,units}`, in seconds.
- `sub_a` out 12: minuend to the BCD subtractor. Always equal to `remain`.
- `sub_b` out 12: subtrahend. Constant 12'h001.
- `sub_diff` in 12: BCD difference. Combinational, valid in the same cycle.
- `phase` out 2: 0 idle, 1 wash, 2 rinse, 3 spin.
- `remain` out 12: BCD seconds left in the current phase.
- `running` out 1: high in RUN.
- `paused` out 1: high in PAUSE.
- `done` out 1: one-cycle pulse when the program completes.
- `err` out 1: one-cycle pulse when a start is rejected.

## Operation
- **States.** IDLE, RUN, PAUSE, ADV.
- **Event priority per cycle.** abort > start > pause > tick.
- **Input capture.** At a start accepted in IDLE, all three durations are captured into shadow registers. Later input changes have no effect on the running program.
- **Start validation.**
  - Any captured digit > 9: start is rejected, `err` pulses, state stays IDLE.
  - Otherwise any value > `MAX_BCD` is clamped to `MAX_BCD`.
- **Phase entry (IDLE→RUN).** Enter the first phase, in wash→rinse→spin order, whose duration is non-zero, and load `remain` with it.
- **All durations zero.** The block does not enter RUN. `done` pulses one cycle after start and the state stays IDLE.
- **RUN, tick with `remain` ≠ 000.** `remain` ← `sub_diff`, i.e. `remain` − 1 in BCD (e.g. 100 → 099).
- **RUN, `remain` == 000.** Go to ADV. Any tick in that cycle is dropped.
- **ADV (one cycle).** Load the next non-zero phase and return to RUN. If none remains, set `phase` = 0 and `remain` = 000, pulse `done`, and go to IDLE.
- **PAUSE.** Ticks are ignored and `remain` holds. A pause pulse returns to RUN.
- **Pause elsewhere.** Ignored in IDLE and ADV.
- **Start outside IDLE.** Ignored.
- **Abort.** From any state, in one cycle: IDLE, `phase` = 0, `remain` = 000. No `done` pulse.
- **Subtractor borrow.** Never observed. `sub_diff` is latched only when `remain` ≠ 000.

## Timing
- **Reset values (`rst_n` low, asynchronous).** State IDLE; `phase` = 0, `remain` = 000, `sub_a` = 000, `running` = 0, `paused` = 0, `done` = 0, `err` = 0; shadow registers cleared.
- **Mid-program reset.** Behaves exactly as abort, immediately and without waiting for a clock edge.
- **Start latency.** Start sampled at edge k gives `running` = 1 and the first `phase`/`remain` valid after edge k.
- **Decrement latency.** A tick sampled at edge k updates `remain` after edge k. One decrement per tick.
- **Phase handover.** Tick to 000 at edge k; ADV entered after edge k+1; next phase loaded after edge k+2. `remain` reads 000 for two cycles.
- **`done`.** Pulses during the cycle after the ADV that finds no further phase, or one cycle after a start with all durations zero. Pulse width is exactly 1 cycle.
- **`err`.** Pulses the cycle after the rejected start. Pulse width is exactly 1 cycle.
- **Input contract.** `tick_1hz` may be asserted in any cycle. The block has no requirement on tick spacing beyond one per cycle.

## Test plan
- **Reset then run.** Reset, then start with wash = 003, rinse = 002, spin = 001, ticks every 10 cycles → `phase` sequence 1,2,3,0; `remain` per phase 003→000, 002→000, 001→000; one `done` pulse; no `err`.
- **BCD borrow and clamp.** Wash = 100, others 000, one tick → `remain` = 099. Then wash = 300 → clamped to 255.
- **Zero-phase skip.** wash = 000, rinse = 005, spin = 000 → first phase = 2. After 5 ticks, ADV, then `done`, IDLE. All zero → `done` one cycle after start, `phase` stays 0.
- **Pause.** Run wash = 010. Pause at `remain` = 007; 5 ticks while paused → `remain` stays 007, `paused` = 1. Pause again → decrements resume.
- **Abort and reset mid-run.** Abort at `remain` = 004 in phase 2 → next cycle `phase` = 0, `remain` = 000, no `done`. Same check with `rst_n` asserted asynchronously mid-cycle.
- **Invalid input and collisions.** wash = 12'h0A5 → `err` pulse, stays IDLE. Start + pause + tick in the same cycle → start wins, `remain` = the loaded value, no pause. Tick coincident with `remain` == 000 → dropped; phase advances per the handover timing.
